vx_reg_scoreboard: RTL and testbench



---
 rtl/vx_reg_scoreboard.sv | 110 +++++++++++
 tb/tb_vx_reg_scoreboard.sv | 388 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vx_reg_scoreboard.sv
// Per-issue-slot register scoreboard: blocks RAW/WAW hazards on pending writes and
// registers accepted instructions into one output stage. SCB_PERF_EN adds perf_stalls.
module vx_reg_scoreboard #(
   parameter int  NUM_WARPS = 4,
   parameter int  NUM_REGS  = 64,
   parameter int  DATAW     = 128,
   parameter int  CTR_W     = 44,
   localparam int WIS_BITS  = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1,
   localparam int NR_BITS   = $clog2(NUM_REGS)
) (
   input  logic                clk,
   input  logic                reset,
   // valid/ready: a transfer happens on a rising edge where valid and ready are both
   // high; ready never depends on valid, and a held scb_* beat stays stable until taken.
   input  logic                ibuf_valid,
   output logic                ibuf_ready,
   input  logic [WIS_BITS-1:0] ibuf_wis,
   input  logic                ibuf_wb,
   input  logic [NR_BITS-1:0]  ibuf_rd,
   input  logic [NR_BITS-1:0]  ibuf_rs1,
   input  logic [NR_BITS-1:0]  ibuf_rs2,
   input  logic [NR_BITS-1:0]  ibuf_rs3,
   input  logic [DATAW-1:0]    ibuf_data,
   output logic                scb_valid,
   input  logic                scb_ready,
   output logic [WIS_BITS-1:0] scb_wis,
   output logic                scb_wb,
   output logic [NR_BITS-1:0]  scb_rd,
   output logic [DATAW-1:0]    scb_data,
   input  logic                wb_valid,
   input  logic [WIS_BITS-1:0] wb_wis,
   input  logic [NR_BITS-1:0]  wb_rd,
   input  logic                wb_eop
`ifdef SCB_PERF_EN
   ,
   output logic [CTR_W-1:0]    perf_stalls
`endif
);

   logic [NUM_REGS-1:0] pending [NUM_WARPS];
   logic [NUM_REGS-1:0] clr_mask;
   logic [NUM_REGS-1:0] pending_eff;
   logic                wb_clr;
   logic                hazard;
   logic                ibuf_fire;

   assign wb_clr = wb_valid & wb_eop;

   // Same-cycle release is bypassed into the lookup so a stall resolves on its writeback.
   always_comb begin
      clr_mask = '0;
      if (wb_clr && (wb_wis == ibuf_wis)) clr_mask[wb_rd] = 1'b1;
   end

   assign pending_eff = pending[ibuf_wis] & ~clr_mask;

   always_comb begin
      hazard = 1'b0;
      if ((ibuf_rs1 != '0) && pending_eff[ibuf_rs1]) hazard = 1'b1;
      if ((ibuf_rs2 != '0) && pending_eff[ibuf_rs2]) hazard = 1'b1;
      if ((ibuf_rs3 != '0) && pending_eff[ibuf_rs3]) hazard = 1'b1;
      if (ibuf_wb && (ibuf_rd != '0) && pending_eff[ibuf_rd]) hazard = 1'b1;
   end

   assign ibuf_ready = ~hazard & (~scb_valid | scb_ready);
   assign ibuf_fire  = ibuf_valid & ibuf_ready;

   // The set is written last so it wins over a clear of the same bit.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int w = 0; w < NUM_WARPS; w++) pending[w] <= '0;
      end else begin
         if (wb_clr) pending[wb_wis][wb_rd] <= 1'b0;
         if (ibuf_fire && ibuf_wb && (ibuf_rd != '0)) pending[ibuf_wis][ibuf_rd] <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         scb_valid <= 1'b0;
         scb_wis   <= '0;
         scb_wb    <= 1'b0;
         scb_rd    <= '0;
         scb_data  <= '0;
      end else if (ibuf_fire) begin
         scb_valid <= 1'b1;
         scb_wis   <= ibuf_wis;
         scb_wb    <= ibuf_wb;
         scb_rd    <= ibuf_rd;
         scb_data  <= ibuf_data;
      end else if (scb_ready) begin
         scb_valid <= 1'b0;
      end
   end

`ifdef SCB_PERF_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         perf_stalls <= '0;
      end else if (ibuf_valid && hazard) begin
         perf_stalls <= perf_stalls + CTR_W'(1);
      end
   end
`endif

   // A release of a register that is not pending points at a writeback bookkeeping bug.
   wb_clr_pending: assert property (@(posedge clk) disable iff (reset)
      wb_clr |-> pending[wb_wis][wb_rd]);

endmodule

// File: tb/tb_vx_reg_scoreboard.sv
// Self-checking bench for vx_reg_scoreboard: hazards, bypass, warp isolation,
// backpressure, x0/WAW and reset; perf_stalls checked when SCB_PERF_EN is defined.
module tb_vx_reg_scoreboard;

   localparam int NW  = 4;
   localparam int NR  = 64;
   localparam int DW  = 128;
   localparam int CTR = 44;
   localparam int WB  = 2;
   localparam int RB  = 6;
   localparam int EW  = WB + 1 + RB + DW;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          ibuf_valid = 1'b0;
   logic          ibuf_ready;
   logic [WB-1:0] ibuf_wis = '0;
   logic          ibuf_wb = 1'b0;
   logic [RB-1:0] ibuf_rd = '0, ibuf_rs1 = '0, ibuf_rs2 = '0, ibuf_rs3 = '0;
   logic [DW-1:0] ibuf_data = '0;
   logic          scb_valid;
   logic          scb_ready = 1'b1;
   logic [WB-1:0] scb_wis;
   logic          scb_wb;
   logic [RB-1:0] scb_rd;
   logic [DW-1:0] scb_data;
   logic          wb_valid = 1'b0;
   logic [WB-1:0] wb_wis = '0;
   logic [RB-1:0] wb_rd = '0;
   logic          wb_eop = 1'b0;
`ifdef SCB_PERF_EN
   logic [CTR-1:0] perf_stalls;
`endif

   int checks = 0;
   int failures = 0;
   logic [EW-1:0] exp_q[$];
   logic [EW-1:0] mon_exp, mon_got;

   vx_reg_scoreboard #(.NUM_WARPS(NW), .NUM_REGS(NR), .DATAW(DW), .CTR_W(CTR)) dut (
      .clk(clk), .reset(reset),
      .ibuf_valid(ibuf_valid), .ibuf_ready(ibuf_ready), .ibuf_wis(ibuf_wis),
      .ibuf_wb(ibuf_wb), .ibuf_rd(ibuf_rd), .ibuf_rs1(ibuf_rs1), .ibuf_rs2(ibuf_rs2),
      .ibuf_rs3(ibuf_rs3), .ibuf_data(ibuf_data),
      .scb_valid(scb_valid), .scb_ready(scb_ready), .scb_wis(scb_wis), .scb_wb(scb_wb),
      .scb_rd(scb_rd), .scb_data(scb_data),
      .wb_valid(wb_valid), .wb_wis(wb_wis), .wb_rd(wb_rd), .wb_eop(wb_eop)
`ifdef SCB_PERF_EN
      , .perf_stalls(perf_stalls)
`endif
   );

   // clock / reset
   always #5 clk = ~clk;

   // scoreboard: every output transfer is compared against the oldest expected entry
   always @(negedge clk) begin
      if (!reset && scb_valid === 1'b1 && scb_ready === 1'b1) begin
         checks++;
         mon_got = {scb_wis, scb_wb, scb_rd, scb_data};
         if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL scb_out: unexpected transfer %h, none expected", mon_got);
         end else begin
            mon_exp = exp_q.pop_front();
            if (mon_got !== mon_exp) begin
               failures++;
               $display("FAIL scb_out: got %h expected %h", mon_got, mon_exp);
            end
         end
      end
   end

   // driver tasks
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [DW-1:0] rand_data();
      return {$urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   task automatic set_ibuf(input int v, input int wis, input int w, input int rd,
                           input int rs1, input int rs2, input int rs3, input logic [DW-1:0] d);
      ibuf_valid = 1'(v);
      ibuf_wis   = WB'(wis);
      ibuf_wb    = 1'(w);
      ibuf_rd    = RB'(rd);
      ibuf_rs1   = RB'(rs1);
      ibuf_rs2   = RB'(rs2);
      ibuf_rs3   = RB'(rs3);
      ibuf_data  = d;
   endtask

   task automatic set_wb(input int v, input int wis, input int rd, input int eop);
      wb_valid = 1'(v);
      wb_wis   = WB'(wis);
      wb_rd    = RB'(rd);
      wb_eop   = 1'(eop);
   endtask

   task automatic push_exp(input int wis, input int w, input int rd, input logic [DW-1:0] d);
      exp_q.push_back({WB'(wis), 1'(w), RB'(rd), d});
   endtask

   task automatic idle();
      set_ibuf(0, 0, 0, 0, 0, 0, 0, '0);
      set_wb(0, 0, 0, 0);
      tick();
   endtask

   // scenarios
   task automatic test_reset();
      reset = 1'b1;
      repeat (3) tick();
      checks++;
      if ({scb_valid, scb_wis, scb_wb, scb_rd, scb_data} !== '0) begin
         failures++;
         $display("FAIL reset_outputs: valid=%b data=%h expected all zero", scb_valid, scb_data);
      end
`ifdef SCB_PERF_EN
      checks++;
      if (perf_stalls !== '0) begin
         failures++;
         $display("FAIL reset_perf: perf_stalls=%0d expected 0", perf_stalls);
      end
`endif
      reset = 1'b0;
      #1;
      checks++;
      if (ibuf_ready !== 1'b1) begin
         failures++;
         $display("FAIL reset_ready: ibuf_ready=%b expected 1", ibuf_ready);
      end
      tick();
   endtask

   task automatic test_raw();
      logic [DW-1:0] d0, d1;
      d0 = rand_data(); d1 = rand_data();
      scb_ready = 1'b1;
      set_ibuf(1, 0, 1, 5, 0, 0, 0, d0); push_exp(0, 1, 5, d0);
      tick();
      checks++;
      if (scb_valid !== 1'b1) begin
         failures++; $display("FAIL raw_first_out: scb_valid=%b expected 1", scb_valid);
      end
      set_ibuf(1, 0, 0, 0, 5, 0, 0, d1);
      #1;
      checks++;
      if (ibuf_ready !== 1'b0) begin
         failures++; $display("FAIL raw_stall: ibuf_ready=%b expected 0", ibuf_ready);
      end
      tick();
      checks++;
      if (scb_valid !== 1'b0) begin
         failures++; $display("FAIL raw_valid_drop: scb_valid=%b expected 0", scb_valid);
      end
      set_wb(1, 0, 5, 1); push_exp(0, 0, 0, d1);
      #1;
      checks++;
      if (ibuf_ready !== 1'b1) begin
         failures++; $display("FAIL raw_bypass: ibuf_ready=%b expected 1", ibuf_ready);
      end
      tick();
      checks++;
      if (scb_valid !== 1'b1) begin
         failures++; $display("FAIL raw_latency: scb_valid=%b expected 1", scb_valid);
      end
      idle();
   endtask

   task automatic test_warp_isolation();
      logic [DW-1:0] d0, d1, d2;
      d0 = rand_data(); d1 = rand_data(); d2 = rand_data();
      set_ibuf(1, 0, 1, 5, 0, 0, 0, d0); push_exp(0, 1, 5, d0);
      tick();
      set_ibuf(1, 1, 0, 0, 0, 5, 0, d1); push_exp(1, 0, 0, d1);
      #1;
      checks++;
      if (ibuf_ready !== 1'b1) begin
         failures++; $display("FAIL warp_other_accept: ibuf_ready=%b expected 1", ibuf_ready);
      end
      tick();
      set_ibuf(1, 0, 0, 0, 0, 0, 5, d2);
      #1;
      checks++;
      if (ibuf_ready !== 1'b0) begin
         failures++; $display("FAIL warp_owner_blocked: ibuf_ready=%b expected 0", ibuf_ready);
      end
      tick();
      set_wb(1, 0, 5, 1); push_exp(0, 0, 0, d2);
      tick();
      idle();
   endtask

   task automatic test_multibeat();
      logic [DW-1:0] d0, d1;
      d0 = rand_data(); d1 = rand_data();
      set_ibuf(1, 2, 1, 7, 0, 0, 0, d0); push_exp(2, 1, 7, d0);
      tick();
      set_ibuf(1, 2, 0, 0, 7, 0, 0, d1);
      for (int i = 0; i < 3; i++) begin
         set_wb(1, 2, 7, 0);
         #1;
         checks++;
         if (ibuf_ready !== 1'b0) begin
            failures++; $display("FAIL multibeat_hold: beat %0d ibuf_ready=%b expected 0", i, ibuf_ready);
         end
         tick();
      end
      set_wb(1, 2, 7, 1); push_exp(2, 0, 0, d1);
      #1;
      checks++;
      if (ibuf_ready !== 1'b1) begin
         failures++; $display("FAIL multibeat_eop: ibuf_ready=%b expected 1", ibuf_ready);
      end
      tick();
      idle();
   endtask

   task automatic test_backpressure();
      logic [DW-1:0] da, db;
      da = rand_data(); db = rand_data();
      scb_ready = 1'b0;
      set_ibuf(1, 3, 0, 0, 0, 0, 0, da); push_exp(3, 0, 0, da);
      tick();
      set_ibuf(1, 3, 0, 4, 1, 2, 3, db); push_exp(3, 0, 4, db);
      for (int i = 0; i < 4; i++) begin
         #1;
         checks++;
         if (ibuf_ready !== 1'b0) begin
            failures++; $display("FAIL bp_ready: cycle %0d ibuf_ready=%b expected 0", i, ibuf_ready);
         end
         checks++;
         if ({scb_valid, scb_data} !== {1'b1, da}) begin
            failures++; $display("FAIL bp_hold: cycle %0d valid=%b data=%h expected 1 %h", i, scb_valid, scb_data, da);
         end
         tick();
      end
      scb_ready = 1'b1;
      #1;
      checks++;
      if (ibuf_ready !== 1'b1) begin
         failures++; $display("FAIL bp_release: ibuf_ready=%b expected 1", ibuf_ready);
      end
      tick();
      checks++;
      if ({scb_valid, scb_data} !== {1'b1, db}) begin
         failures++; $display("FAIL bp_next: valid=%b data=%h expected 1 %h", scb_valid, scb_data, db);
      end
      idle();
   endtask

   task automatic test_x0_waw();
      logic [DW-1:0] d0, d1, d2, d3, d4;
      d0 = rand_data(); d1 = rand_data(); d2 = rand_data(); d3 = rand_data(); d4 = rand_data();
      set_ibuf(1, 1, 1, 0, 0, 0, 0, d0); push_exp(1, 1, 0, d0);
      tick();
      set_ibuf(1, 1, 1, 0, 0, 0, 0, d1); push_exp(1, 1, 0, d1);
      #1;
      checks++;
      if (ibuf_ready !== 1'b1) begin
         failures++; $display("FAIL x0_no_stall: ibuf_ready=%b expected 1", ibuf_ready);
      end
      tick();
      set_ibuf(1, 1, 1, 9, 0, 0, 0, d2); push_exp(1, 1, 9, d2);
      tick();
      set_ibuf(1, 1, 1, 9, 0, 0, 0, d3);
      #1;
      checks++;
      if (ibuf_ready !== 1'b0) begin
         failures++; $display("FAIL waw_stall: ibuf_ready=%b expected 0", ibuf_ready);
      end
      tick();
      set_wb(1, 1, 9, 1); push_exp(1, 1, 9, d3);
      #1;
      checks++;
      if (ibuf_ready !== 1'b1) begin
         failures++; $display("FAIL waw_release: ibuf_ready=%b expected 1", ibuf_ready);
      end
      tick();
      set_wb(0, 0, 0, 0);
      set_ibuf(1, 1, 0, 0, 9, 0, 0, d4);
      #1;
      checks++;
      if (ibuf_ready !== 1'b0) begin
         failures++; $display("FAIL set_wins: ibuf_ready=%b expected 0", ibuf_ready);
      end
      set_wb(1, 1, 9, 1); push_exp(1, 0, 0, d4);
      tick();
      idle();
   endtask

   task automatic test_back_to_back();
      logic [DW-1:0] d;
      int wis, rd;
      scb_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         d = rand_data();
         wis = int'($urandom_range(0, NW - 1));
         rd = int'($urandom_range(0, NR - 1));
         set_ibuf(1, wis, 0, rd, int'($urandom_range(0, NR - 1)), int'($urandom_range(0, NR - 1)),
                  int'($urandom_range(0, NR - 1)), d);
         push_exp(wis, 0, rd, d);
         #1;
         checks++;
         if (ibuf_ready !== 1'b1) begin
            failures++; $display("FAIL b2b_ready: beat %0d ibuf_ready=%b expected 1", i, ibuf_ready);
         end
         tick();
      end
      idle();
   endtask

   task automatic test_reset_perf();
      logic [DW-1:0] d0, d1;
      d0 = rand_data(); d1 = rand_data();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      tick();
      scb_ready = 1'b0;
      set_ibuf(1, 0, 1, 12, 0, 0, 0, d0); push_exp(0, 1, 12, d0);
      tick();
      set_ibuf(1, 0, 0, 0, 12, 0, 0, d1);
      repeat (3) tick();
`ifdef SCB_PERF_EN
      checks++;
      if (perf_stalls !== CTR'(3)) begin
         failures++; $display("FAIL perf_count: perf_stalls=%0d expected 3", perf_stalls);
      end
`endif
      reset = 1'b1;
      tick();
      exp_q.delete();
      checks++;
      if ({scb_valid, scb_wis, scb_wb, scb_rd, scb_data} !== '0) begin
         failures++; $display("FAIL midreset_outputs: valid=%b data=%h expected all zero", scb_valid, scb_data);
      end
`ifdef SCB_PERF_EN
      checks++;
      if (perf_stalls !== '0) begin
         failures++; $display("FAIL midreset_perf: perf_stalls=%0d expected 0", perf_stalls);
      end
`endif
      reset = 1'b0;
      #1;
      checks++;
      if (ibuf_ready !== 1'b1) begin
         failures++; $display("FAIL midreset_accept: ibuf_ready=%b expected 1", ibuf_ready);
      end
      push_exp(0, 0, 0, d1);
      tick();
      checks++;
      if (scb_valid !== 1'b1) begin
         failures++; $display("FAIL midreset_out: scb_valid=%b expected 1", scb_valid);
      end
      scb_ready = 1'b1;
      idle();
`ifdef SCB_PERF_EN
      checks++;
      if (perf_stalls !== '0) begin
         failures++; $display("FAIL perf_after_reset: perf_stalls=%0d expected 0", perf_stalls);
      end
`endif
   endtask

   initial begin
      test_reset();
      test_raw();
      test_warp_isolation();
      test_multibeat();
      test_backpressure();
      test_x0_waw();
      test_back_to_back();
      test_reset_perf();
      repeat (3) tick();
      checks++;
      if (exp_q.size() != 0) begin
         failures++; $display("FAIL drain: %0d expected outputs never appeared, expected 0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
